bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 114 +++++++++++
 tb/tb_bin2bcd_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble, one bit per clock).
// Optional saturation of out-of-range inputs: define BIN2BCD_SAT_EN.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] sh_q, sh_d;
  logic [15:0] scr_q, scr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic [15:0] adj;
  logic [29:0] shifted;
`ifdef BIN2BCD_SAT_EN
  logic        sat_q, sat_d;
`endif

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < 4; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    // The carry out of the thousands digit is dropped, which keeps the low four decimal digits.
    shifted = {adj, sh_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
`ifdef BIN2BCD_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_SHIFT;
          sh_d    = bin;
          scr_d   = 16'h0000;
          cnt_d   = 4'd0;
`ifdef BIN2BCD_SAT_EN
          sat_d   = (bin > 14'd9999);
`endif
        end
      end
      S_SHIFT: begin
        scr_d = shifted[29:14];
        sh_d  = shifted[13:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          state_d = S_DONE;
`ifdef BIN2BCD_SAT_EN
          bcd_d   = sat_q ? 16'h9999 : shifted[29:14];
          ovf_d   = sat_q;
`else
          bcd_d   = shifted[29:14];
          ovf_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= 14'd0;
      scr_q   <= 16'h0000;
      cnt_q   <= 4'd0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
`ifdef BIN2BCD_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
`ifdef BIN2BCD_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bcd         = bcd_q;
  assign ovf         = ovf_q;
  assign busy        = (state_q == S_SHIFT);
  assign done        = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: arithmetic reference model with per-cycle compare plus directed vectors.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin = 14'd0;
  logic [15:0] bcd;
  logic        busy, done, ovf;
  logic [1:0]  dbg_state;

  bin2bcd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .bcd(bcd), .busy(busy), .done(done), .ovf(ovf), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_bcd(input int v);
    int x;
`ifdef BIN2BCD_SAT_EN
    x = (v > 9999) ? 9999 : v;
`else
    x = v % 10000;
`endif
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic logic ref_ovf(input int v);
`ifdef BIN2BCD_SAT_EN
    return (v > 9999);
`else
    return 1'b0 & (v > 9999);
`endif
  endfunction

  logic [15:0] exp_q[$];
  logic        eovf_q[$];
  int          m_left = 0;
  logic [15:0] m_bcd = 16'h0000;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_bcd = 16'h0000; m_ovf = 1'b0; m_done = 1'b0;
      exp_q.delete(); eovf_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_bcd  = exp_q.pop_front();
          m_ovf  = eovf_q.pop_front();
          m_done = 1'b1;
        end
      end else if (start) begin
        exp_q.push_back(ref_bcd(int'(bin)));
        eovf_q.push_back(ref_ovf(int'(bin)));
        m_left = 14;
      end
    end
  end

  // ---------------- per-cycle scoreboard compare ----------------
  always @(negedge clk) begin
    chk("cyc_bcd",  int'(bcd),  int'(m_bcd));
    chk("cyc_busy", int'(busy), int'(m_left > 0));
    chk("cyc_done", int'(done), int'(m_done));
    chk("cyc_ovf",  int'(ovf),  int'(m_ovf));
  end

  // ---------------- driver tasks ----------------
  task automatic conv(input int v, input int exp_b, input int exp_o, input bit scramble);
    int  n_busy;
    bit  got;
    bin = 14'(v); start = 1'b1;
    tick();
    start = 1'b0;
    n_busy = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) n_busy++;
      if (scramble) bin = 14'($urandom_range(0, 16383));
    end
    chk("done_seen", int'(got), 1);
    chk("busy_cycles", n_busy, 14);
    chk("res_bcd", int'(bcd), exp_b);
    chk("res_ovf", int'(ovf), exp_o);
    tick();
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int d1, d2, nd;
    bit got;
    #1;
    chk("rst_bcd", int'(bcd), 16'h0000);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_busy", int'(busy), 0);

    conv(1234, 16'h1234, 0, 1'b0);
    conv(0, 16'h0000, 0, 1'b0);
    conv(9999, 16'h9999, 0, 1'b0);
`ifdef BIN2BCD_SAT_EN
    conv(12345, 16'h9999, 1, 1'b0);
`else
    conv(12345, 16'h2345, 0, 1'b0);
`endif
    conv(16383, ref_bcd(16383), int'(ref_ovf(16383)), 1'b0);
    conv(8191, 16'h8191, 0, 1'b1);

    // start ignored mid-conversion
    bin = 14'd42; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bin = 14'd77; start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("coll_done", int'(got), 1);
    chk("coll_bcd", int'(bcd), 16'h0042);
    count_dones(20, nd);
    chk("coll_single", nd, 0);
    tick();

    // back-to-back with start held
    bin = 14'd100; start = 1'b1;
    d1 = -1; d2 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
      end
    end
    chk("b2b_period", d2 - d1, 15);
    chk("b2b_bcd", int'(bcd), 16'h0100);
    tick();
    start = 1'b0;
    repeat (20) tick();

    // reset in the middle of a conversion
    conv(42, 16'h0042, 0, 1'b0);
    bin = 14'd500; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_bcd", int'(bcd), 16'h0000);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    tick();
    rst_n = 1'b1;
    count_dones(25, nd);
    chk("midrst_no_done", nd, 0);

    // start on the first edge after reset release
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    conv(7, 16'h0007, 0, 1'b0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
